// File: rtl/fakeram130_64x7_ctrl_if.sv
// Request/response and macro-side bus for the fakeram130 64x7 controller.
// The slave modport is the controller's view; the master modport is the view of the requester/macro side.
interface fakeram130_64x7_ctrl_if #(
    parameter int BITS       = 7,
    parameter int ADDR_WIDTH = 6
);
    logic                  req_v_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [BITS-1:0]       req_data_i;
    logic [BITS-1:0]       req_mask_i;

    logic                  resp_v_o;
    logic                  resp_ready_i;
    logic [BITS-1:0]       resp_data_o;

    logic                  init_done_o;

    logic                  ram_ce_o;
    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [BITS-1:0]       ram_wd_o;
    logic [BITS-1:0]       ram_wmask_o;
    logic [BITS-1:0]       ram_rd_i;

    modport slave (
        input  req_v_i, req_we_i, req_addr_i, req_data_i, req_mask_i,
        input  resp_ready_i, ram_rd_i,
        output req_ready_o, resp_v_o, resp_data_o, init_done_o,
        output ram_ce_o, ram_we_o, ram_addr_o, ram_wd_o, ram_wmask_o
    );

    modport master (
        output req_v_i, req_we_i, req_addr_i, req_data_i, req_mask_i,
        output resp_ready_i, ram_rd_i,
        input  req_ready_o, resp_v_o, resp_data_o, init_done_o,
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_wd_o, ram_wmask_o
    );
endinterface

// File: rtl/fakeram130_64x7_ctrl.sv
// Controller for a 64x7 single-port macro: zero-fills the array after reset, then serves
// masked writes and credit-limited reads through a 3-entry in-order response FIFO.
//
// state | meaning
// INIT  | zero-fill, one masked-all write per cycle at fill_addr
// RUN   | accept requests while fewer than 3 reads are outstanding
module fakeram130_64x7_ctrl #(
    parameter int BITS       = 7,
    parameter int WORD_DEPTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input logic                   clk,
    input logic                   reset,
    fakeram130_64x7_ctrl_if.slave bus
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [1:0]            credit;
    logic                  rd_pend;
    logic [BITS-1:0]       fifo_mem [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            count;

    logic run;
    logic accept;
    logic rd_accept;
    logic push;
    logic pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign run              = (state == ST_RUN);
    assign bus.req_ready_o  = run && (credit != 2'd3);
    assign accept           = bus.req_v_i && bus.req_ready_o;
    assign rd_accept        = accept && !bus.req_we_i;
    assign push             = rd_pend;
    assign pop              = bus.resp_v_o && bus.resp_ready_i;
    assign bus.resp_v_o     = (count != 2'd0);
    assign bus.resp_data_o  = fifo_mem[rd_ptr];
    assign bus.init_done_o  = run;

    // Macro pins are gated by reset directly so nothing reaches the array while reset is held.
    always_comb begin
        bus.ram_ce_o    = 1'b0;
        bus.ram_we_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_wd_o    = '0;
        bus.ram_wmask_o = '0;
        if (!reset) begin
            if (!run) begin
                bus.ram_ce_o    = 1'b1;
                bus.ram_we_o    = 1'b1;
                bus.ram_addr_o  = fill_addr;
                bus.ram_wmask_o = '1;
            end else if (accept) begin
                bus.ram_ce_o    = 1'b1;
                bus.ram_we_o    = bus.req_we_i;
                bus.ram_addr_o  = bus.req_addr_i;
                bus.ram_wd_o    = bus.req_data_i;
                bus.ram_wmask_o = bus.req_mask_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            fill_addr <= '0;
        end else if (!run) begin
            fill_addr <= fill_addr + 1'b1;
            if (fill_addr == LAST_ADDR) begin
                state <= ST_RUN;
            end
        end
    end

    // Credit counts FIFO entries plus the read in flight, so the FIFO can never overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            credit  <= 2'd0;
            count   <= 2'd0;
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            rd_pend <= rd_accept;
            if (push) begin
                fifo_mem[wr_ptr] <= bus.ram_rd_i;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
            case ({rd_accept, pop})
                2'b10:   credit <= credit + 2'd1;
                2'b01:   credit <= credit - 2'd1;
                default: ;
            endcase
        end
    end
endmodule
